// File: rtl/framebuffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_ram
// Description : Simple-dual-port frame/image RAM on a single clock. One write
//               port, one read port with a 1- or 2-stage registered read
//               pipeline and a valid flag, selectable read-during-write
//               behaviour, and a hardware clear engine that fills the whole
//               array with a constant.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1   clock, everything on posedge
//   rst_n      in   1   asynchronous active-low reset (array is not reset)
//   wr_en      in   1   write strobe (ignored while busy)
//   wr_addr    in   AW  write address
//   wr_data    in   DW  write data
//   rd_en      in   1   read request (ignored while busy)
//   rd_addr    in   AW  read address
//   rd_data    out  DW  read data, qualified by rd_valid; holds otherwise
//   rd_valid   out  1   rd_data is the result of a request ReadLatency ago
//   clear_req  in   1   single-cycle pulse: fill the array with ClearValue
//   busy       out  1   clear in progress
// ============================================================================
module framebuffer_ram #(
  parameter int                  AddressWidth = 14,
  parameter int                  DataWidth    = 8,
  parameter int                  ReadLatency  = 1,
  parameter int                  WriteMode    = 0,
  parameter logic [DataWidth-1:0] ClearValue  = '0,
  parameter bit                  ClearOnReset = 1'b0,
  parameter string               RAMFILE      = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [AddressWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0]    wr_data,
  input  logic                    rd_en,
  input  logic [AddressWidth-1:0] rd_addr,
  output logic [DataWidth-1:0]    rd_data,
  output logic                    rd_valid,
  input  logic                    clear_req,
  output logic                    busy
);

  localparam int                      c_DEPTH    = 2 ** AddressWidth;
  localparam logic [AddressWidth-1:0] c_CNT_LAST = '1;
  localparam logic [AddressWidth-1:0] c_CNT_ONE  = {{(AddressWidth-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [DataWidth-1:0] r_mem [c_DEPTH];

  // --------------------------------------------------------------------------
  // Clear engine
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  r_state;
  logic                    r_busy;
  logic [AddressWidth-1:0] r_clr_cnt;
  logic                    r_boot;     // high only until the first clock after reset release
  logic                    w_start;

  // The boot flag lets the first post-reset edge launch a clear without any
  // external request when ClearOnReset is set.
  assign w_start = clear_req | (r_boot & ClearOnReset);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_clr_cnt <= '0;
      r_boot    <= 1'b1;
    end else begin
      r_boot <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_CLEAR;
            r_busy    <= 1'b1;
            r_clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          // clear_req is deliberately not looked at here: no restart.
          if (r_clr_cnt == c_CNT_LAST) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + c_CNT_ONE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_clr_cnt <= '0;
        end
      endcase
    end
  end

  assign busy = r_busy;

  // --------------------------------------------------------------------------
  // Write port: the clear engine owns the port while busy
  // --------------------------------------------------------------------------
  logic                    w_mem_we;
  logic [AddressWidth-1:0] w_mem_waddr;
  logic [DataWidth-1:0]    w_mem_wdata;
  logic                    w_user_we;

  assign w_user_we   = wr_en & ~r_busy;
  assign w_mem_we    = r_busy | wr_en;
  assign w_mem_waddr = r_busy ? r_clr_cnt  : wr_addr;
  assign w_mem_wdata = r_busy ? ClearValue : wr_data;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline, stage 1: registered array read
  // --------------------------------------------------------------------------
  logic                 w_rd_acc;
  logic                 w_collide;
  logic [DataWidth-1:0] r_s1_data;
  logic                 r_s1_valid;

  assign w_rd_acc  = rd_en & ~r_busy;
  assign w_collide = w_user_we & (wr_addr == rd_addr);

  // Data only moves on an accepted read so rd_data holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) begin
        // Write-first forwards the incoming word; read-first sees the array
        // value from before this edge's write.
        if ((WriteMode == 1) && w_collide) begin
          r_s1_data <= wr_data;
        end else begin
          r_s1_data <= r_mem[rd_addr];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline, optional stage 2
  // --------------------------------------------------------------------------
  generate
    if (ReadLatency >= 2) begin : g_rl2
      logic [DataWidth-1:0] r_s2_data;
      logic                 r_s2_valid;

      // Not gated by busy: reads already in flight when a clear starts finish.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s2_data  <= '0;
          r_s2_valid <= 1'b0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign rd_data  = r_s2_data;
      assign rd_valid = r_s2_valid;
    end else begin : g_rl1
      assign rd_data  = r_s1_data;
      assign rd_valid = r_s1_valid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_ram
// Description : Self-checking bench for framebuffer_ram. Two instances share
//               one clock: DUT0 (RL=1, read-first, clear=FF, no boot clear)
//               and DUT1 (RL=2, write-first, clear=3C, boot clear). Read
//               expectations go into a per-DUT queue when a request is
//               driven and are popped by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_ram;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     [2];
  logic          wr_en     [2];
  logic [AW-1:0] wr_addr   [2];
  logic [DW-1:0] wr_data   [2];
  logic          rd_en     [2];
  logic [AW-1:0] rd_addr   [2];
  logic [DW-1:0] rd_data   [2];
  logic          rd_valid  [2];
  logic          clear_req [2];
  logic          busy      [2];

  framebuffer_ram #(
    .AddressWidth(AW), .DataWidth(DW), .ReadLatency(1), .WriteMode(0),
    .ClearValue(8'hFF), .ClearOnReset(1'b0), .RAMFILE("")
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
    .clear_req(clear_req[0]), .busy(busy[0])
  );

  framebuffer_ram #(
    .AddressWidth(AW), .DataWidth(DW), .ReadLatency(2), .WriteMode(1),
    .ClearValue(8'h3C), .ClearOnReset(1'b1), .RAMFILE("")
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
    .clear_req(clear_req[1]), .busy(busy[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] last_data [2];
  bit            mon_en = 1'b0;

  typedef struct {
    int            d;
    bit            we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    bit            re;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [24];

  function automatic int rl(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result monitor: data, latency, spurious/missing valid and hold behaviour.
  task automatic mon(input int d);
    exp_t e;
    bit   have;
    have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (have) e = (d == 0) ? q0[0] : q1[0];
    if (!rst_n[d]) begin
      last_data[d] = '0;
      chk($sformatf("dut%0d_reset_rd_data", d), rd_data[d], 0);
      chk($sformatf("dut%0d_reset_rd_valid", d), rd_valid[d], 0);
      return;
    end
    if (rd_valid[d]) begin
      if (!have) begin
        chk($sformatf("dut%0d_spurious_valid", d), rd_valid[d], 0);
      end else begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk($sformatf("dut%0d_latency", d), cyc, e.due);
        chk($sformatf("dut%0d_rd_data", d), rd_data[d], e.data);
      end
      last_data[d] = rd_data[d];
    end else begin
      chk($sformatf("dut%0d_hold", d), rd_data[d], last_data[d]);
      if (have && e.due < cyc) begin
        chk($sformatf("dut%0d_missing_valid", d), rd_valid[d], 1);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0);
      mon(1);
    end
  end

  task automatic all_idle();
    for (int k = 0; k < 2; k++) begin
      wr_en[k]     = 1'b0;
      rd_en[k]     = 1'b0;
      clear_req[k] = 1'b0;
    end
  endtask

  // One cycle of stimulus on DUT d; the other DUT is idle. Returns #1 after
  // the sampling edge with every strobe low.
  task automatic drive(input int d, input bit we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input bit re,
                       input logic [AW-1:0] ra, input bit push,
                       input logic [DW-1:0] exp, input bit clr);
    exp_t e;
    all_idle();
    wr_en[d]     = we;
    wr_addr[d]   = wa;
    wr_data[d]   = wd;
    rd_en[d]     = re;
    rd_addr[d]   = ra;
    clear_req[d] = clr;
    if (re && push) begin
      e.data = exp;
      e.due  = cyc + rl(d);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    all_idle();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Length of the next busy pulse, bounded.
  task automatic count_busy(input int d, output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy[d]) n++;
      else if (n > 0) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // d we wa wd re ra exp
    tbl[0]  = '{0, 1'b1, 4'd3,  8'hA5, 1'b0, 4'd0,  8'h00};
    tbl[1]  = '{0, 1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  8'hA5};
    tbl[2]  = '{0, 1'b1, 4'd5,  8'h11, 1'b0, 4'd0,  8'h00};
    tbl[3]  = '{0, 1'b1, 4'd5,  8'h22, 1'b1, 4'd5,  8'h11};
    tbl[4]  = '{0, 1'b0, 4'd0,  8'h00, 1'b1, 4'd5,  8'h22};
    tbl[5]  = '{0, 1'b1, 4'd0,  8'h10, 1'b1, 4'd5,  8'h22};
    tbl[6]  = '{0, 1'b1, 4'd1,  8'h20, 1'b1, 4'd0,  8'h10};
    tbl[7]  = '{0, 1'b1, 4'd2,  8'h30, 1'b1, 4'd1,  8'h20};
    tbl[8]  = '{0, 1'b1, 4'd7,  8'h77, 1'b1, 4'd2,  8'h30};
    tbl[9]  = '{0, 1'b1, 4'd3,  8'h5A, 1'b1, 4'd7,  8'h77};
    tbl[10] = '{0, 1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  8'h5A};
    tbl[11] = '{0, 1'b1, 4'd15, 8'hF0, 1'b1, 4'd0,  8'h10};
    tbl[12] = '{0, 1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 8'hF0};
    tbl[13] = '{1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd9,  8'h3C};
    tbl[14] = '{1, 1'b1, 4'd0,  8'h01, 1'b0, 4'd0,  8'h00};
    tbl[15] = '{1, 1'b1, 4'd1,  8'h02, 1'b0, 4'd0,  8'h00};
    tbl[16] = '{1, 1'b1, 4'd2,  8'h03, 1'b0, 4'd0,  8'h00};
    tbl[17] = '{1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd0,  8'h01};
    tbl[18] = '{1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd1,  8'h02};
    tbl[19] = '{1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd2,  8'h03};
    tbl[20] = '{1, 1'b1, 4'd5,  8'h11, 1'b0, 4'd0,  8'h00};
    tbl[21] = '{1, 1'b1, 4'd5,  8'h22, 1'b1, 4'd5,  8'h22};
    tbl[22] = '{1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd5,  8'h22};
    tbl[23] = '{1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 8'h3C};

    for (int k = 0; k < 2; k++) begin
      rst_n[k]     = 1'b1;
      wr_en[k]     = 1'b0;
      wr_addr[k]   = '0;
      wr_data[k]   = '0;
      rd_en[k]     = 1'b0;
      rd_addr[k]   = '0;
      clear_req[k] = 1'b0;
      last_data[k] = '0;
    end
    #2;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    #1;
    mon_en = 1'b1;
    idle(3);

    // Reset state
    chk("dut0_reset_busy", busy[0], 0);
    chk("dut1_reset_busy", busy[1], 0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Boot clear on DUT1 only
    count_busy(1, n);
    chk("dut1_boot_clear_cycles", n, 16);
    chk("dut0_no_boot_clear", busy[0], 0);

    // Main read/write function, collisions, back-to-back reads
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].d, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra,
            1'b1, tbl[i].exp, 1'b0);
    end
    idle(3);

    // DUT0 clear: writes and reads dropped while busy, re-request ignored
    drive(0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy[0]) n++;
      drive(0, 1'b1, 4'd4, 8'h99, 1'b1, 4'd4, 1'b0, 8'h00, (i == 5));
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (busy[0]) n++;
    end
    chk("dut0_clear_busy_cycles", n, 16);
    for (int a = 0; a < 16; a++) begin
      drive(0, 1'b0, 4'd0, 8'h00, 1'b1, a[AW-1:0], 1'b1, 8'hFF, 1'b0);
    end
    idle(3);

    // DUT1: read in flight at clear start, reset mid-clear, boot clear again
    drive(1, 1'b1, 4'd6, 8'hAA, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 1'b1, 8'hAA, 1'b1);
    idle(8);
    chk("dut1_busy_before_reset", busy[1], 1);
    rst_n[1] = 1'b0;
    #1;
    chk("dut1_async_busy", busy[1], 0);
    chk("dut1_async_rd_valid", rd_valid[1], 0);
    chk("dut1_async_rd_data", rd_data[1], 0);
    idle(2);
    rst_n[1] = 1'b1;
    count_busy(1, n);
    chk("dut1_reclear_cycles", n, 16);
    for (int a = 0; a < 16; a++) begin
      drive(1, 1'b0, 4'd0, 8'h00, 1'b1, a[AW-1:0], 1'b1, 8'h3C, 1'b0);
    end
    idle(4);

    chk("dut0_queue_drained", q0.size(), 0);
    chk("dut1_queue_drained", q1.size(), 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
